// File: rtl/mem_writeback.sv
// Memory/writeback stage: aligns and extends load data, registers the register-file write port,
// keeps RAM read data across input stalls and counts retired instructions.
module mem_writeback #(
    parameter int unsigned INSTRET_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [31:0]              pc_i,
    input  logic [31:0]              inst_i,
    input  logic [31:0]              r0data_i,
    input  logic [31:0]              result_i,
    input  logic [31:0]              memrdata_i,
    output logic                     valid_ro,
    input  logic                     ready_i,
    output logic [31:0]              pc_ro,
    output logic [31:0]              inst_ro,
    output logic                     rd_we_ro,
    output logic [4:0]               rd_addr_ro,
    output logic [31:0]              rd_data_ro,
    output logic [INSTRET_WIDTH-1:0] instret_o
);

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_OPIMM  = 7'b0010011,
        OP_OP     = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111
    } opcode_e;

    logic                     r_valid;
    logic [31:0]              r_pc;
    logic [31:0]              r_inst;
    logic                     r_rd_we;
    logic [4:0]               r_rd_addr;
    logic [31:0]              r_rd_data;
    logic [INSTRET_WIDTH-1:0] r_instret;
    logic                     r_fresh;
    logic [31:0]              r_hold;

    logic                     w_cke;
    logic [6:0]               w_opcode;
    logic [4:0]               w_rd;
    logic [2:0]               w_funct3;
    logic                     w_is_load;
    logic                     w_writes;
    logic [1:0]               w_addr;
    logic [31:0]              w_ldraw;
    logic [15:0]              w_shifted;
    logic [31:0]              w_load_data;
    logic                     w_unused;

    assign w_cke   = ~r_valid | ready_i;
    assign ready_o = w_cke;

    assign w_opcode = inst_i[6:0];
    assign w_rd     = inst_i[11:7];
    assign w_funct3 = inst_i[14:12];

    // Only the low two address bits matter for alignment.
    assign w_unused = ^r0data_i[31:2];

    // r_fresh marks a cycle whose RAM data belongs to the beat on the input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fresh <= 1'b1;
            r_hold  <= '0;
        end else begin
            r_fresh <= ~valid_i | w_cke;
            if (r_fresh) begin
                r_hold <= memrdata_i;
            end
        end
    end

    assign w_ldraw   = r_fresh ? memrdata_i : r_hold;
    assign w_addr    = r0data_i[1:0] + inst_i[21:20];
    assign w_shifted = 16'(w_ldraw >> {w_addr, 3'b000});

    always_comb begin
        w_is_load = 1'b0;
        w_writes  = 1'b0;
        case (w_opcode)
            OP_LOAD: begin
                w_is_load = 1'b1;
                w_writes  = 1'b1;
            end
            OP_OPIMM, OP_OP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
                w_writes = 1'b1;
            end
            default: begin
                w_writes = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_load_data = '1;
        case (w_funct3)
            3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_load_data = {24'h000000, w_shifted[7:0]};
            3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_load_data = {16'h0000, w_shifted[15:0]};
            3'b010:  w_load_data = w_ldraw;
            default: w_load_data = '1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_inst    <= '0;
            r_rd_we   <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
        end else if (w_cke) begin
            r_valid   <= valid_i;
            r_pc      <= pc_i;
            r_inst    <= inst_i;
            r_rd_we   <= valid_i & w_writes & (w_rd != 5'd0);
            r_rd_addr <= w_rd;
            r_rd_data <= w_is_load ? w_load_data : result_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instret <= '0;
        end else if (r_valid & ready_i) begin
            r_instret <= r_instret + INSTRET_WIDTH'(1);
        end
    end

    assign valid_ro   = r_valid;
    assign pc_ro      = r_pc;
    assign inst_ro    = r_inst;
    assign rd_we_ro   = r_rd_we;
    assign rd_addr_ro = r_rd_addr;
    assign rd_data_ro = r_rd_data;
    assign instret_o  = r_instret;

endmodule
